muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32: operand and result width; legal values are 8 to 64 in steps of 8.
REQ-002 The clock port SHALL be clk, input, 1 bit; all state changes on its rising edge.
REQ-003 The reset port SHALL be rst, input, 1 bit; asynchronous, active-high, and it clears all state.
REQ-004 Start SHALL be an input, 1 bit: request a new operation; it is sampled only in IDLE.
REQ-005 MDOp SHALL be an input, 3 bits, encoded as RV32M funct3:
- 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
- 100 DIV, 101 DIVU, 110 REM, 111 REMU
REQ-006 A and B SHALL be inputs, XLEN bits each: operands (rs1 and rs2).
REQ-007 Busy SHALL be an output, 1 bit: high while an operation is in progress.
REQ-008 Done SHALL be an output, 1 bit: a single-cycle pulse marking MDRes valid.
REQ-009 MDRes SHALL be an output, XLEN bits: the result, held until the next accepted Start.

Function
REQ-010 The FSM SHALL have states IDLE, CALC and FIN; it resets to IDLE.
REQ-011 In IDLE with Start=1, the block SHALL latch A, B and MDOp, clear the iteration counter, and go to CALC.
- Exception: the special cases of REQ-016 and REQ-017 go directly to FIN.
REQ-012 CALC SHALL perform exactly one iteration per clock for XLEN clocks, then go to FIN.
- Multiply: shift-add on operand magnitudes.
- Divide: restoring division on operand magnitudes.
REQ-013 FIN SHALL assert Done=1 and Busy=0 for one cycle, with MDRes valid, then return to IDLE.
REQ-014 Latency from the edge sampling Start to Done high SHALL be XLEN+1 clocks for normal ops and 1 clock for special cases.
REQ-015 Signedness and result selection:
- MULH: both operands signed; MULHSU: A signed, B unsigned; MULHU: both unsigned.
- The product is 2*XLEN bits. MUL returns the low XLEN bits; the MULH variants return the high XLEN bits.
- Signed results SHALL be formed by two's-complement negation of the magnitude result when the operand signs differ.
REQ-016 Divide by zero (B=0), for all four divide ops:
- DIV and DIVU return all-ones.
- REM and REMU return A.
REQ-017 Signed overflow (DIV or REM with A = most-negative value and B = all-ones):
- DIV returns A.
- REM returns 0.
REQ-018 Division signs: the quotient is truncated toward zero, and the remainder takes the sign of the dividend.
REQ-019 Start SHALL be ignored in CALC and FIN; operand or MDOp changes after acceptance SHALL NOT affect the result.
REQ-020 In the IDLE cycle immediately following FIN, Start=1 SHALL be accepted, allowing back-to-back operations.

Reset
REQ-021 While rst=1, outputs SHALL be Busy=0, Done=0 and MDRes=0; the state SHALL be IDLE and the counter and operand registers 0.
REQ-022 Reset asserted during CALC SHALL abort the operation immediately, with no Done pulse.
REQ-023 After rst deasserts, the first rising edge with Start=1 SHALL be accepted.

Verification (XLEN=32)
REQ-024 Bench SHALL cover multiply signedness and latency:
- MUL A=7, B=0xFFFFFFFD -> MDRes=0xFFFFFFEB.
- Done exactly 33 clocks after Start is sampled; Busy high for 32 clocks.
- MULH A=0x80000000, B=0x80000000 -> 0x40000000.
- MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF -> 0xFFFFFFFF.
- MULHU A=0xFFFFFFFF, B=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-025 Bench SHALL cover signed and unsigned division:
- DIV A=0xFFFFFFF9, B=2 -> 0xFFFFFFFD.
- REM with the same operands -> 0xFFFFFFFF.
- DIVU A=100, B=7 -> 14.
- REMU with the same operands -> 2.
REQ-026 Bench SHALL cover the special cases:
- DIVU A=5, B=0 -> 0xFFFFFFFF; REM A=5, B=0 -> 5; Done 1 clock after Start.
- DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
REQ-027 Bench SHALL cover Start during an operation: pulse Start with new operands mid-CALC -> ignored; the original result is delivered and only one Done pulse occurs.
REQ-028 Bench SHALL cover reset mid-operation: assert rst 10 clocks into a DIV ->
- Busy, Done and MDRes go to 0 immediately, with no Done pulse.
- A subsequent MUL 3*4 returns 12 with normal latency.
REQ-029 Bench SHALL cover back-to-back operations: MULHU 1*1 -> 0, then DIV 9/3 -> 3 with Start held continuously; both Done pulses occur with correct results.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide unit.
// Shift-add multiply and restoring divide, one bit per clock.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Start,
  input  logic [2:0]      MDOp,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] MDRes
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic              neg;
  logic [XLEN-1:0]   opb;
  logic [2*XLEN-1:0] acc;

  logic              a_neg, b_neg, div0, ovf, special, in_neg;
  logic [XLEN-1:0]   a_mag, b_mag, spec_res;

  logic [XLEN:0]     msum, dsh, ddiff;
  logic [2*XLEN-1:0] acc_n, prod_s;
  logic [XLEN-1:0]   div_sel, fin_res;

  // Operand preparation for the request presented in IDLE
  always_comb begin
    a_neg = 1'b0;
    b_neg = 1'b0;
    unique case (MDOp)
      3'b001, 3'b100, 3'b110: begin
        a_neg = A[XLEN-1];
        b_neg = B[XLEN-1];
      end
      3'b010: a_neg = A[XLEN-1];
      default: ;
    endcase
    a_mag   = a_neg ? -A : A;
    b_mag   = b_neg ? -B : B;
    in_neg  = (MDOp == 3'b110) ? a_neg : (a_neg ^ b_neg);
    div0    = MDOp[2] && (B == '0);
    ovf     = MDOp[2] && !MDOp[0] && (A == MIN_NEG) && (B == '1);
    special = div0 || ovf;
    if (div0)
      spec_res = MDOp[1] ? A : '1;
    else
      spec_res = MDOp[1] ? '0 : A;
  end

  // One multiply or divide step on acc = {hi, lo}
  always_comb begin
    msum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opb : '0)};
    dsh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    ddiff = dsh - {1'b0, opb};
    if (op[2]) begin
      if (ddiff[XLEN])
        acc_n = {dsh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else
        acc_n = {ddiff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_n = {msum, acc[XLEN-1:1]};
    end
    prod_s  = neg ? -acc_n : acc_n;
    div_sel = op[1] ? acc_n[2*XLEN-1:XLEN] : acc_n[XLEN-1:0];
    if (op[2])
      fin_res = neg ? -div_sel : div_sel;
    else if (op[1:0] == 2'b00)
      fin_res = prod_s[XLEN-1:0];
    else
      fin_res = prod_s[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    Busy    = 1'b0;
    Done    = 1'b0;
    unique case (state)
      IDLE: if (Start) state_n = special ? FIN : CALC;
      CALC: begin
        Busy = 1'b1;
        if (cnt == LAST) state_n = FIN;
      end
      FIN: begin
        Done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      op    <= '0;
      neg   <= 1'b0;
      opb   <= '0;
      acc   <= '0;
      MDRes <= '0;
    end else if (state == IDLE && Start) begin
      cnt <= '0;
      op  <= MDOp;
      neg <= in_neg;
      opb <= b_mag;
      acc <= {{XLEN{1'b0}}, a_mag};
      if (special) MDRes <= spec_res;
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      acc <= acc_n;
      if (cnt == LAST) MDRes <= fin_res;
    end
  end

endmodule
